// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional JMP predecode is selected by the FETCH_JMP_PREDECODE_EN macro.
package fetch_pkg;

  localparam int PC_W  = 5;
  localparam int INS_W = 16;

  localparam logic [3:0] OP_JMP = 4'b1111;
  localparam logic [3:0] OP_BNE = 4'b1110;

  // RUN fetches sequentially; HALT parks fetch on a self-jump until reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational JMP detector: flags opcode JMP and extracts its absolute target.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [3:0]      opcode_i,
  input  logic [PC_W-1:0] target_field_i,
  output logic            is_jmp_o,
  output logic [PC_W-1:0] jmp_target_o
);

  // Opcode compare and target pass-through.
  always_comb begin
    is_jmp_o     = (opcode_i == OP_JMP);
    jmp_target_o = target_field_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, fetch counter.
// Build option FETCH_JMP_PREDECODE_EN consumes JMPs in fetch and parks on a
// self-jump (HALT). Without it, JMPs flow to decode like any instruction.
//
// Flow control: stall is downstream back-pressure. A fetch is accepted into
// IF/ID only on a RUN cycle with stall=0 and branch_taken=0; otherwise the
// PC and IF/ID contents hold. branch_taken wins over stall and over a JMP.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 5'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INS_W-1:0]  imem_ins,
  output logic [INS_W-1:0]  ifid_ins,
  output logic [PC_W-1:0]   ifid_pc,
  output logic              ifid_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INS_W-1:0]   ifid_ins_q, ifid_ins_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [15:0]        fetch_count_q, fetch_count_d;

`ifdef FETCH_JMP_PREDECODE_EN
  logic               is_jmp;
  logic [PC_W-1:0]    jmp_target;

  fetch_predecode u_predecode (
    .opcode_i       (imem_ins[15:12]),
    .target_field_i (imem_ins[PC_W-1:0]),
    .is_jmp_o       (is_jmp),
    .jmp_target_o   (jmp_target)
  );
`endif

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      ifid_ins_q    <= '0;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_ins_q    <= ifid_ins_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state logic: redirect, hold on stall, JMP predecode, or sequential fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_ins_d    = ifid_ins_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          pc_d         = branch_target;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
`ifdef FETCH_JMP_PREDECODE_EN
          if (is_jmp) begin
            ifid_valid_d = 1'b0;
            if (jmp_target == pc_q) begin
              state_d = ST_HALT;
            end else begin
              pc_d = jmp_target;
            end
          end else begin
            ifid_ins_d   = imem_ins;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + 1'b1;
            if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
          end
`else
          ifid_ins_d   = imem_ins;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 1'b1;
          if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
`endif
        end
      end
      ST_HALT: begin
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output mapping.
  always_comb begin
    imem_addr   = pc_q;
    ifid_ins    = ifid_ins_q;
    ifid_pc     = ifid_pc_q;
    ifid_valid  = ifid_valid_q;
    fetch_count = fetch_count_q;
`ifdef FETCH_JMP_PREDECODE_EN
    halted      = (state_q == ST_HALT);
`else
    halted      = 1'b0;
`endif
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 5'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, meaning the synchronous, active-high reset; one clock domain only.
REQ-004 SHALL have port stall, input, 1, meaning downstream cannot accept; hold PC and the IF/ID register.
REQ-005 SHALL have port branch_taken, input, 1, meaning execute redirects fetch this cycle.
REQ-006 SHALL have port branch_target, input, 5, meaning the redirect address, valid when branch_taken=1.
REQ-007 SHALL have port imem_addr, output, 5, meaning the address to the combinational instruction memory.
REQ-008 SHALL have port imem_ins, input, 16, meaning the instruction at imem_addr, same cycle.
REQ-009 SHALL have port ifid_ins, output, 16, meaning the registered instruction to decode.
REQ-010 SHALL have port ifid_pc, output, 5, meaning the address of ifid_ins.
REQ-011 SHALL have port ifid_valid, output, 1, meaning ifid_ins is a real instruction rather than a bubble.
REQ-012 SHALL have port halted, output, 1, meaning fetch is parked on a self-jump.
REQ-013 SHALL have port fetch_count, output, 16, meaning the number of valid instructions delivered.

Function
REQ-014 SHALL drive imem_addr = pc combinationally; no memory latency.
REQ-015 SHALL implement FSM states RUN and HALT; reset enters RUN.
REQ-016 In RUN with stall=0 and branch_taken=0, SHALL:
  - register ifid_ins<=imem_ins, ifid_pc<=pc, ifid_valid<=1;
  - advance pc<=pc+1, mod 32, so 31 wraps to 0.
REQ-017 In RUN with stall=1 and branch_taken=0, SHALL hold pc, ifid_ins, ifid_pc, ifid_valid and fetch_count unchanged.
REQ-018 branch_taken=1 in RUN SHALL set pc<=branch_target and ifid_valid<=0, regardless of stall (branch has priority).
REQ-019 branch_taken=1 SHALL take priority over a same-cycle JMP predecode.
REQ-020 fetch_count SHALL increment on each cycle that loads ifid_valid<=1, saturating at 16'hFFFF.
REQ-021 In HALT, SHALL:
  - keep ifid_valid=0 and pc frozen;
  - ignore stall and branch_taken;
  - exit only via reset.
REQ-022 halted SHALL be 1 exactly while in HALT.
REQ-023 Opcode field SHALL be ins[15:12]; JMP SHALL be 4'b1111, with the absolute target in ins[4:0].

Reset
REQ-024 On reset=1 at a clock edge, SHALL set:
  - pc=RESET_PC, state=RUN;
  - ifid_ins=16'h0000, ifid_pc=5'd0, ifid_valid=0;
  - halted=0, fetch_count=0.
REQ-025 Reset SHALL override all inputs, including mid-stall, mid-redirect and HALT.

Configuration
REQ-026 Macro FETCH_JMP_PREDECODE_EN SHALL select JMP handling.
REQ-027 With FETCH_JMP_PREDECODE_EN defined, a JMP fetched in RUN with stall=0 and branch_taken=0 SHALL:
  - set pc<=ins[4:0] and ifid_valid<=0 (JMP consumed, not forwarded);
  - if ins[4:0]==pc, enter HALT instead.
REQ-028 Without FETCH_JMP_PREDECODE_EN, JMP SHALL be forwarded like any instruction, redirection SHALL come only via branch_taken, and halted SHALL be tied 0.

Structure
REQ-029 Shared package fetch_pkg SHALL hold:
  - PC_W=5, INS_W=16;
  - OP_JMP=4'b1111, OP_BNE=4'b1110;
  - the FSM state typedef.
REQ-030 JMP detection and target extraction SHALL live in one combinational sub-module, fetch_predecode.

Verification
REQ-031 Reset then 3 free cycles -> imem_addr 0,1,2,3; ifid_pc 0,1,2 with ifid_valid=1; fetch_count=3.
REQ-032 stall=1 for 2 cycles at pc=3 -> imem_addr stays 3, ifid_pc stays 2, fetch_count unchanged, resumes at 3.
REQ-033 branch_taken=1, branch_target=5, stall=1 at pc=8 -> next imem_addr=5, ifid_valid=0.
REQ-034 (EN) imem_ins=16'hF014 at pc=24 -> next imem_addr=20, ifid_valid=0; non-EN -> ifid_ins=16'hF014, pc=25.
REQ-035 (EN) imem_ins=16'hF01F at pc=31 -> halted=1, imem_addr held 31, branch_taken ignored until reset.
REQ-036 Non-jump at pc=31 -> next imem_addr=0; reset asserted in HALT -> RUN, imem_addr=RESET_PC next cycle.
